// File: rtl/accel_feeder.sv
// accel_feeder: streams weight/image bytes into an accelerator RAM and collects its result bytes.
module accel_feeder #(
   parameter int WEIGHT_BYTES = 54,
   parameter int DATA_BYTES   = 64,
   parameter int RESULT_BYTES = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       wload,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       mode,
   output logic [7:0] din,
   output logic       ram_en,
   input  logic       out_data_flag,
   input  logic [7:0] acc_dout,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int MAXB = (WEIGHT_BYTES > DATA_BYTES) ? WEIGHT_BYTES : DATA_BYTES;
   localparam int BW = $clog2(MAXB + 1);
   localparam int RW = $clog2(RESULT_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, WAIT_RES, FINISH} state_t;
   state_t state_q, state_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [7:0] din_q, res_q;
   logic mode_q, ram_en_q, res_valid_q, xfer, cap;
   assign s_ready   = state_q == LOAD_W || state_q == LOAD_D;
   assign xfer      = s_valid && s_ready;
   // once all results are in, further flags are ignored until FINISH
   assign cap       = state_q == WAIT_RES && out_data_flag && rcnt_q != RW'(RESULT_BYTES);
   assign busy      = state_q != IDLE;
   assign done      = state_q == FINISH;
   assign din       = din_q;
   assign mode      = mode_q;
   assign ram_en    = ram_en_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_q;
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      rcnt_d  = rcnt_q;
      tcnt_d  = tcnt_q;
      err     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = wload ? LOAD_W : LOAD_D;
            bcnt_d  = '0;
            rcnt_d  = '0;
            tcnt_d  = '0;
         end
         LOAD_W: if (xfer) begin
            bcnt_d  = bcnt_q == BW'(WEIGHT_BYTES - 1) ? '0 : bcnt_q + BW'(1);
            state_d = bcnt_q == BW'(WEIGHT_BYTES - 1) ? LOAD_D : LOAD_W;
         end
         LOAD_D: if (xfer) begin
            bcnt_d  = bcnt_q == BW'(DATA_BYTES - 1) ? '0 : bcnt_q + BW'(1);
            state_d = bcnt_q == BW'(DATA_BYTES - 1) ? WAIT_RES : LOAD_D;
            tcnt_d  = '0;
            rcnt_d  = '0;
         end
         WAIT_RES: if (rcnt_q == RW'(RESULT_BYTES)) state_d = FINISH;
         else if (cap) begin
            rcnt_d = rcnt_q + RW'(1);
            tcnt_d = '0;
         end else if (tcnt_q == TW'(TIMEOUT)) begin
            err     = 1'b1;
            state_d = IDLE;
         end else tcnt_d = tcnt_q + TW'(1);
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bcnt_q      <= '0;
         rcnt_q      <= '0;
         tcnt_q      <= '0;
         din_q       <= '0;
         mode_q      <= 1'b0;
         ram_en_q    <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         rcnt_q      <= rcnt_d;
         tcnt_q      <= tcnt_d;
         ram_en_q    <= xfer;
         res_valid_q <= cap;
         if (xfer) begin
            din_q  <= s_data;
            mode_q <= state_q == LOAD_W;
         end
         if (cap) res_q <= acc_dout;
      end
   end
endmodule

// File: tb/tb_accel_feeder.sv
// tb_accel_feeder: randomized frames checked every cycle against a remaining-bytes model.
module tb_accel_feeder;
   localparam int W = 54, D = 64, R = 1, TO = 255;
   logic clk = 0, rst = 1, start = 0, wload = 0, s_valid = 0, out_data_flag = 0;
   logic [7:0] s_data = 0, acc_dout = 0;
   logic s_ready, mode, ram_en, res_valid, busy, done, err;
   logic [7:0] din, res_data;
   accel_feeder dut (
      .clk(clk), .rst(rst), .start(start), .wload(wload), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .mode(mode), .din(din), .ram_en(ram_en), .out_data_flag(out_data_flag),
      .acc_dout(acc_dout), .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done), .err(err)
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0, cyc = 0, tot_w = 0, tot_d = 0, last_en = -10, run = 0;
   int rem_w = 0, rem_d = 0, age = 0, got = 0;
   bit waiting = 0, fin = 0, e_en = 0, e_mode = 0, e_rv = 0;
   logic [7:0] e_din = 0, e_res = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // model: bytes still owed per phase, then a result wait with an age counter
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_w = 0; rem_d = 0; waiting = 0; fin = 0; age = 0; got = 0;
         e_en = 0; e_mode = 0; e_rv = 0; e_din = 0; e_res = 0;
      end else begin
         e_en = 0;
         e_rv = 0;
         if (fin) fin = 0;
         else if (waiting) begin
            if (got == R) begin waiting = 0; fin = 1; end
            else if (out_data_flag) begin got++; age = 0; e_rv = 1; e_res = acc_dout; end
            else if (age == TO) waiting = 0;
            else age++;
         end else if (rem_w + rem_d > 0) begin
            if (s_valid) begin
               e_en = 1; e_din = s_data; e_mode = rem_w > 0;
               if (rem_w > 0) rem_w--;
               else begin
                  rem_d--;
                  if (rem_d == 0) begin waiting = 1; age = 0; got = 0; end
               end
            end
         end else if (start) begin
            rem_w = wload ? W : 0;
            rem_d = D;
         end
      end
   end
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         chk("s_ready", s_ready, rem_w + rem_d > 0);
         chk("ram_en", ram_en, e_en);
         chk("din", din, e_din);
         chk("mode", mode, e_mode);
         chk("res_valid", res_valid, e_rv);
         chk("res_data", res_data, e_res);
         chk("busy", busy, (rem_w + rem_d > 0) || waiting || fin);
         chk("done", done, fin);
         chk("err", err, waiting && got < R && age == TO && !out_data_flag);
         if (ram_en) begin
            if (mode) tot_w++; else tot_d++;
            run = (last_en == cyc - 1) ? run + 1 : 1;
            last_en = cyc;
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic load(input bit wl, input int pat, input bit noise, input int abort_at);
      int n = 0, i = 0, total;
      total = (wl ? W : 0) + D;
      start = 1; wload = wl;
      tick();
      start = 0; wload = 0;
      while (n < total && i < 3000) begin
         s_valid = pat == 0 ? 1'b1 : pat == 1 ? (i % 2 == 0) : 1'($urandom_range(0, 1));
         s_data = 8'($urandom);
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            out_data_flag = 1'($urandom_range(0, 1));
            acc_dout = 8'($urandom);
         end
         @(negedge clk);
         if (s_valid && s_ready) n++;
         tick();
         i++;
         if (abort_at > 0 && n == (wl ? W : 0) + abort_at) break;
      end
      s_valid = 0; start = 0; out_data_flag = 0;
      if (abort_at == 0) chk("load_accepted", n, total);
   endtask
   task automatic result(input int dly, input logic [7:0] v, input bit lit);
      int k = 0;
      repeat (dly) tick();
      out_data_flag = 1; acc_dout = v;
      tick();
      out_data_flag = 0;
      if (lit) begin
         @(negedge clk);
         chk("lit_res_valid", res_valid, 1'b1);
         chk("lit_res_data", res_data, 8'hA5);
         chk("lit_done_early", done, 1'b0);
         @(negedge clk);
         chk("lit_done", done, 1'b1);
      end
      while (busy && k < 10) begin tick(); k++; end
      chk("idle_after_frame", busy, 1'b0);
   endtask
   initial begin
      int bw, bd, cnt;
      bit seen_done;
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int bw, bd, cnt;
      bit seen_done;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_ready, 0); chk("rst_mode", mode, 0); chk("rst_ram_en", ram_en, 0);
      chk("rst_res_valid", res_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_err", err, 0); chk("rst_din", din, 8'h00); chk("rst_res_data", res_data, 8'h00);
      rst = 0;
      tick();
      bw = tot_w; bd = tot_d;
      load(1, 0, 0, 0);
      result(3, 8'hA5, 1);
      chk("w_count", tot_w - bw, 54);
      chk("d_count", tot_d - bd, 64);
      chk("contiguous_run", run, 118);
      bw = tot_w; bd = tot_d;
      load(0, 1, 0, 0);
      result(5, 8'($urandom), 0);
      chk("toggle_w_count", tot_w - bw, 0);
      chk("toggle_d_count", tot_d - bd, 64);
      bw = tot_w; bd = tot_d;
      load(1, 2, 1, 0);
      result(2, 8'($urandom), 0);
      chk("noise_w_count", tot_w - bw, 54);
      chk("noise_d_count", tot_d - bd, 64);
      load(0, 0, 0, 0);
      cnt = 0; seen_done = 0;
      @(negedge clk);
      while (!err && cnt < 400) begin
         seen_done |= done;
         cnt++;
         @(negedge clk);
      end
      chk("timeout_cycles", cnt, 255);
      @(negedge clk);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_done", seen_done | done, 0);
      tick();
      load(0, 0, 0, 20);
      #1 rst = 1;
      #1;
      chk("arst_ram_en", ram_en, 0); chk("arst_busy", busy, 0); chk("arst_s_ready", s_ready, 0);
      chk("arst_din", din, 8'h00); chk("arst_mode", mode, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (3) tick();
      chk("arst_no_ram_en", ram_en, 0);
      bd = tot_d;
      load(0, 0, 0, 0);
      result(1, 8'($urandom), 0);
      chk("reload_d_count", tot_d - bd, 64);
      for (int f = 0; f < 8; f++) begin
         load(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 0);
         result($urandom_range(0, 30), 8'($urandom), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
